// File: rtl/systolic_pkg.sv
// Shared types for the systolic front end: feeder state encoding and the
// zero-flush length needed for the farthest PE to finish accumulating.
package systolic_pkg;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    FLUSH,
    DONE
  } feeder_state_t;

  function automatic int flush_len(input int arr_height, input int arr_width, input int pe_lat);
    return arr_height + arr_width - 1 + pe_lat;
  endfunction

endpackage

// File: rtl/systolic_feeder_if.sv
// Job control, slice handshake and skewed edge buses between the slice source,
// the feeder and the systolic array.
interface systolic_feeder_if #(
  parameter int WIDTH      = 16,
  parameter int ARR_HEIGHT = 4,
  parameter int ARR_WIDTH  = 4,
  parameter int K_BITS     = 8
);
  logic                        start;
  logic [K_BITS-1:0]           k_len;
  logic                        in_valid;
  logic                        in_ready;
  logic [ARR_HEIGHT*WIDTH-1:0] in_a_vec;
  logic [ARR_WIDTH*WIDTH-1:0]  in_b_vec;
  logic [ARR_HEIGHT*WIDTH-1:0] out_a;
  logic [ARR_WIDTH*WIDTH-1:0]  out_b;
  logic                        busy;
  logic                        done;

  modport master (
    output start, k_len, in_valid, in_a_vec, in_b_vec,
    input  in_ready, out_a, out_b, busy, done
  );

  modport slave (
    input  start, k_len, in_valid, in_a_vec, in_b_vec,
    output in_ready, out_a, out_b, busy, done
  );
endinterface

// File: rtl/skew_delay_line.sv
// Fixed-depth shift register for one edge lane; DEPTH cycles of latency, no
// backpressure (shifts every cycle), synchronous clear on reset.
module skew_delay_line #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= din;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign dout = stage[DEPTH-1];

endmodule

// File: rtl/systolic_feeder.sv
// Skews K-slices onto the array's west/north edges (lane i/j delayed i+1/j+1 cycles), flushes zeros,
// then pulses done; stalls inject zero bubbles. FEEDER_STALL_CNT_EN adds a saturating stall_cnt output.
module systolic_feeder
  import systolic_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int ARR_HEIGHT = 4,
  parameter int ARR_WIDTH  = 4,
  parameter int K_BITS     = 8,
  parameter int PE_LAT     = 1
) (
  input  logic                clk,
  input  logic                reset,
  systolic_feeder_if.slave    bus
`ifdef FEEDER_STALL_CNT_EN
  ,
  output logic [31:0]         stall_cnt
`endif
);

  localparam int FLUSH_LEN = flush_len(ARR_HEIGHT, ARR_WIDTH, PE_LAT);
  localparam int FC_BITS   = $clog2(FLUSH_LEN + 1);

  feeder_state_t        state;
  feeder_state_t        state_nxt;
  logic [K_BITS-1:0]    k_len_q;
  logic [K_BITS-1:0]    beat_cnt;
  logic [FC_BITS-1:0]   flush_cnt;
  logic                 accept;
  logic                 last_beat;
  logic                 start_acc;

  assign accept    = bus.in_valid && (state == STREAM);
  assign last_beat = (beat_cnt == k_len_q - K_BITS'(1));
  assign start_acc = (state == IDLE) && bus.start;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      k_len_q   <= '0;
      beat_cnt  <= '0;
      flush_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (start_acc) begin
        k_len_q  <= bus.k_len;
        beat_cnt <= '0;
      end else if (accept) begin
        beat_cnt <= beat_cnt + K_BITS'(1);
      end
      if (state == FLUSH) flush_cnt <= flush_cnt + FC_BITS'(1);
      else                flush_cnt <= '0;
    end
  end

  always_comb begin
    state_nxt    = state;
    bus.in_ready = 1'b0;
    bus.busy     = 1'b0;
    bus.done     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) state_nxt = (bus.k_len != '0) ? STREAM : DONE;
      end
      STREAM: begin
        bus.in_ready = 1'b1;
        bus.busy     = 1'b1;
        if (accept && last_beat) state_nxt = FLUSH;
      end
      FLUSH: begin
        bus.busy = 1'b1;
        if (flush_cnt == FC_BITS'(FLUSH_LEN - 1)) state_nxt = DONE;
      end
      DONE: begin
        bus.done  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Every cycle injects a slot; non-accepted cycles inject zeros so A and B stay aligned.
  logic [ARR_HEIGHT*WIDTH-1:0] a_skew;
  logic [ARR_WIDTH*WIDTH-1:0]  b_skew;

  for (genvar i = 0; i < ARR_HEIGHT; i++) begin : g_a
    logic [WIDTH-1:0] slot;
    assign slot = accept ? bus.in_a_vec[i*WIDTH +: WIDTH] : '0;
    skew_delay_line #(.WIDTH(WIDTH), .DEPTH(i + 1)) u_dl (
      .clk   (clk),
      .reset (reset),
      .din   (slot),
      .dout  (a_skew[i*WIDTH +: WIDTH])
    );
  end

  for (genvar j = 0; j < ARR_WIDTH; j++) begin : g_b
    logic [WIDTH-1:0] slot;
    assign slot = accept ? bus.in_b_vec[j*WIDTH +: WIDTH] : '0;
    skew_delay_line #(.WIDTH(WIDTH), .DEPTH(j + 1)) u_dl (
      .clk   (clk),
      .reset (reset),
      .din   (slot),
      .dout  (b_skew[j*WIDTH +: WIDTH])
    );
  end

  assign bus.out_a = a_skew;
  assign bus.out_b = b_skew;

`ifdef FEEDER_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (reset)                                                 stall_cnt <= '0;
    else if (start_acc)                                        stall_cnt <= '0;
    else if (state == STREAM && !bus.in_valid && stall_cnt != '1) stall_cnt <= stall_cnt + 32'd1;
  end
`endif

endmodule
